// File: rtl/arb_mux_n_pkg.sv
// Shared definitions for the arbitrated mux: arbitration mode codes and
// width helpers reused by other parametrised blocks.
package arb_mux_n_pkg;

    localparam int ARB_MODE_FIXED = 0;
    localparam int ARB_MODE_RR    = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    // Select fields never collapse to zero bits, even for a single-bit index space.
    function automatic int sel_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/arb_mux_n_grant.sv
// Combinational grant picker: scans requests upward from a start index with
// wrap-around; fixed-priority mode always starts the scan at channel 0.
module rr_grant
    import arb_mux_n_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int SELW = 2
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    input  logic            mode,
    output logic [NCH-1:0]  grant,
    output logic [SELW-1:0] gidx
);

    logic [SELW-1:0] w_start;

    // An out-of-range pointer can only come from a corrupted state; fall back to 0.
    assign w_start = (mode && (int'(ptr) < NCH)) ? ptr : '0;

    always_comb begin
        int  v_idx;
        logic v_found;
        grant   = '0;
        gidx    = '0;
        v_found = 1'b0;
        v_idx   = 0;
        for (int k = 0; k < NCH; k++) begin
            v_idx = int'(w_start) + k;
            if (v_idx >= NCH) begin
                v_idx = v_idx - NCH;
            end
            if (!v_found && req[v_idx]) begin
                v_found      = 1'b1;
                grant[v_idx] = 1'b1;
                gidx         = SELW'(v_idx);
            end
        end
    end

endmodule

// File: rtl/arb_mux_n.sv
// One-stage registered N:1 arbiter mux with valid/ready on both sides.
// Holds the output register, the round-robin pointer and the handshake.
module arb_mux_n
    import arb_mux_n_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int MODE  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NCH-1:0]             in_valid,
    input  logic [NCH*WIDTH-1:0]       in_data,
    output logic [NCH-1:0]             in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic [sel_width(NCH)-1:0]  out_sel,
    input  logic                       out_ready
);

    localparam int SELW = sel_width(NCH);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [SELW-1:0]  r_sel;
    logic [SELW-1:0]  r_ptr;

    logic [WIDTH-1:0] w_data [NCH];
    logic [NCH-1:0]   w_grant;
    logic [SELW-1:0]  w_gidx;
    logic             w_load_en;
    logic             w_xfer;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_unpack
            assign w_data[gi] = in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    rr_grant #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_grant (
        .req   (in_valid),
        .ptr   (r_ptr),
        .mode  (MODE == ARB_MODE_RR),
        .grant (w_grant),
        .gidx  (w_gidx)
    );

    // Load when empty or when the current word leaves in this same cycle.
    assign w_load_en = !r_valid || out_ready;
    assign in_ready  = (w_load_en && !rst) ? w_grant : '0;
    assign w_xfer    = |in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
            r_ptr   <= '0;
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_data  <= w_data[w_gidx];
            r_sel   <= w_gidx;
            if (MODE == ARB_MODE_RR) begin
                r_ptr <= (w_gidx == SELW'(NCH - 1)) ? '0 : w_gidx + 1'b1;
            end
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_sel   = r_sel;

endmodule

// File: tb/tb_arb_mux_n.sv
// Directed bench for arb_mux_n: round-robin 4-channel, fixed-priority
// 4-channel and round-robin 3-channel instances on one clock.
module tb_arb_mux_n;

    logic clk;
    logic rst;

    // Round-robin, 4 channels, 32 bits
    logic [3:0]   rr_in_valid;
    logic [127:0] rr_in_data;
    logic [3:0]   rr_in_ready;
    logic         rr_out_valid;
    logic [31:0]  rr_out_data;
    logic [1:0]   rr_out_sel;
    logic         rr_out_ready;

    // Fixed priority, 4 channels, 32 bits
    logic [3:0]   fp_in_valid;
    logic [127:0] fp_in_data;
    logic [3:0]   fp_in_ready;
    logic         fp_out_valid;
    logic [31:0]  fp_out_data;
    logic [1:0]   fp_out_sel;
    logic         fp_out_ready;

    // Round-robin, 3 channels, 8 bits
    logic [2:0]   n3_in_valid;
    logic [23:0]  n3_in_data;
    logic [2:0]   n3_in_ready;
    logic         n3_out_valid;
    logic [7:0]   n3_out_data;
    logic [1:0]   n3_out_sel;
    logic         n3_out_ready;

    int n_checks;
    int n_errors;

    arb_mux_n #(.WIDTH(32), .NCH(4), .MODE(1)) dut_rr (
        .clk(clk), .rst(rst),
        .in_valid(rr_in_valid), .in_data(rr_in_data), .in_ready(rr_in_ready),
        .out_valid(rr_out_valid), .out_data(rr_out_data), .out_sel(rr_out_sel),
        .out_ready(rr_out_ready)
    );

    arb_mux_n #(.WIDTH(32), .NCH(4), .MODE(0)) dut_fp (
        .clk(clk), .rst(rst),
        .in_valid(fp_in_valid), .in_data(fp_in_data), .in_ready(fp_in_ready),
        .out_valid(fp_out_valid), .out_data(fp_out_data), .out_sel(fp_out_sel),
        .out_ready(fp_out_ready)
    );

    arb_mux_n #(.WIDTH(8), .NCH(3), .MODE(1)) dut_n3 (
        .clk(clk), .rst(rst),
        .in_valid(n3_in_valid), .in_data(n3_in_data), .in_ready(n3_in_ready),
        .out_valid(n3_out_valid), .out_data(n3_out_data), .out_sel(n3_out_sel),
        .out_ready(n3_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0]  rot_sel [8];
    logic [1:0]  n3_sel  [6];

    initial begin
        n_checks = 0;
        n_errors = 0;
        rot_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        n3_sel  = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};

        rst = 1'b1;
        rr_in_valid = '0; rr_in_data = '0; rr_out_ready = 1'b0;
        fp_in_valid = '0; fp_in_data = '0; fp_out_ready = 1'b0;
        n3_in_valid = '0; n3_in_data = '0; n3_out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset_valid", 32'(rr_out_valid), 32'd0);
        chk("reset_data",  rr_out_data,       32'd0);
        chk("reset_sel",   32'(rr_out_sel),   32'd0);

        // Fill the register from ch1 and stall it
        rr_in_valid = 4'b0010;
        rr_in_data[32 +: 32] = 32'hAAAA0001;
        #1;
        chk("fill_ready", 32'(rr_in_ready), 32'h2);
        tick();
        rr_in_valid = '0;
        tick();
        chk("stall_valid", 32'(rr_out_valid), 32'd1);
        chk("stall_data",  rr_out_data,       32'hAAAA0001);

        // Reset mid-stall; out_ready high so only rst can hold in_ready low
        rst = 1'b1;
        rr_in_valid = 4'b1111;
        rr_out_ready = 1'b1;
        #1;
        chk("rst_ready_forced", 32'(rr_in_ready), 32'h0);
        tick();
        rst = 1'b0;
        rr_in_valid = '0;
        #1;
        chk("midrst_valid", 32'(rr_out_valid), 32'd0);
        chk("midrst_data",  rr_out_data,       32'd0);
        chk("midrst_sel",   32'(rr_out_sel),   32'd0);

        rr_in_valid = 4'b0100;
        rr_in_data[64 +: 32] = 32'h22220002;
        #1;
        chk("post_rst_ready", 32'(rr_in_ready), 32'h4);
        tick();
        chk("post_rst_sel",  32'(rr_out_sel), 32'd2);
        chk("post_rst_data", rr_out_data,     32'h22220002);

        // ptr now 3: ch0/ch1 requesting, scan wraps past idle ch3
        rr_in_valid = 4'b0011;
        rr_in_data[0 +: 32]  = 32'h000000C0;
        rr_in_data[32 +: 32] = 32'h000000C1;
        #1;
        chk("wrap_ready", 32'(rr_in_ready), 32'h1);
        tick();
        chk("wrap_sel",  32'(rr_out_sel), 32'd0);
        chk("wrap_data", rr_out_data,     32'h000000C0);
        chk("ptr1_ready", 32'(rr_in_ready), 32'h2);
        tick();
        chk("ptr1_sel", 32'(rr_out_sel), 32'd1);

        // Drain with no requests
        rr_in_valid = '0;
        tick();
        chk("drain_valid", 32'(rr_out_valid), 32'd0);
        chk("drain_hold_sel", 32'(rr_out_sel), 32'd1);

        // Rotation from ptr=0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rr_in_data[i*32 +: 32] = 32'hC0DE0000 + 32'(i);
        end
        rr_in_valid = 4'b1111;
        rr_out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("rot%0d_valid", k), 32'(rr_out_valid), 32'd1);
            chk($sformatf("rot%0d_sel", k),   32'(rr_out_sel),   32'(rot_sel[k]));
            chk($sformatf("rot%0d_data", k),  rr_out_data,       32'hC0DE0000 + 32'(rot_sel[k]));
        end

        // Backpressure: ch3 word held, ch2 waits
        rr_in_valid = 4'b0100;
        rr_in_data[64 +: 32] = 32'hBEEF0002;
        rr_out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp%0d_ready", k), 32'(rr_in_ready), 32'h0);
            chk($sformatf("bp%0d_data", k),  rr_out_data,      32'hC0DE0003);
            tick();
        end
        rr_out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(rr_in_ready), 32'h4);
        tick();
        chk("bp_load_valid", 32'(rr_out_valid), 32'd1);
        chk("bp_load_sel",   32'(rr_out_sel),   32'd2);
        chk("bp_load_data",  rr_out_data,       32'hBEEF0002);
        rr_in_valid = '0;
        tick();
        chk("bp_empty_valid", 32'(rr_out_valid), 32'd0);
        chk("bp_empty_data",  rr_out_data,       32'hBEEF0002);

        // Fixed priority: lowest index wins, repeatedly
        fp_in_valid = 4'b1010;
        fp_in_data[32 +: 32] = 32'h11111111;
        fp_in_data[96 +: 32] = 32'h33333333;
        fp_out_ready = 1'b1;
        #1;
        chk("fp_ready", 32'(fp_in_ready), 32'h2);
        tick();
        chk("fp_data", fp_out_data,     32'h11111111);
        chk("fp_sel",  32'(fp_out_sel), 32'd1);
        chk("fp_ready_again", 32'(fp_in_ready), 32'h2);
        fp_in_valid = 4'b1000;
        #1;
        chk("fp_ready_ch3", 32'(fp_in_ready), 32'h8);
        tick();
        chk("fp_data_ch3", fp_out_data,     32'h33333333);
        chk("fp_sel_ch3",  32'(fp_out_sel), 32'd3);

        // Three channels, round-robin
        for (int i = 0; i < 3; i++) begin
            n3_in_data[i*8 +: 8] = 8'hA0 + 8'(i);
        end
        n3_in_valid = 3'b111;
        n3_out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("n3_%0d_sel", k),  32'(n3_out_sel),  32'(n3_sel[k]));
            chk($sformatf("n3_%0d_data", k), 32'(n3_out_data), 32'h000000A0 + 32'(n3_sel[k]));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
